ctrl_shadow_reg: RTL and testbench



---
 rtl/ctrl_shadow_pkg.sv | 17 +
 rtl/ctrl_shadow_reg_if.sv | 31 +++
 rtl/ctrl_shadow_reg_shadow_store.sv | 50 +++++
 rtl/ctrl_shadow_reg.sv | 136 +++++++++++++
 tb/tb_ctrl_shadow_reg.sv | 214 +++++++++++++++++++++
 5 files changed

// File: rtl/ctrl_shadow_pkg.sv
// Shared types and constants for the shadowed control register.
package ctrl_shadow_pkg;

    localparam int unsigned CTRL_DW = 5;

    typedef enum logic [4:0] {
        CTRL_MODE_OFF     = 5'b00000,
        CTRL_MODE_SAFE    = 5'b10101,
        CTRL_MODE_DEFAULT = 5'b11111
    } ctrl_mode_e;

    typedef enum logic {
        PH_IDLE   = 1'b0,
        PH_STAGED = 1'b1
    } phase_e;

endpackage

// File: rtl/ctrl_shadow_reg_if.sv
// Software register-bus port of ctrl_shadow_reg: write/read strobes and
// the registered read response.
interface ctrl_shadow_reg_if #(
    parameter int unsigned DW = 5
);

    logic          we_i;
    logic [DW-1:0] wd_i;
    logic          re_i;
    logic          rd_valid_o;
    logic [DW-1:0] rd_data_o;

    // Software side: issues writes and reads, consumes the response.
    modport master (
        output we_i,
        output wd_i,
        output re_i,
        input  rd_valid_o,
        input  rd_data_o
    );

    // Register side: accepts strobes, produces the response.
    modport slave (
        input  we_i,
        input  wd_i,
        input  re_i,
        output rd_valid_o,
        output rd_data_o
    );

endinterface

// File: rtl/ctrl_shadow_reg_shadow_store.sv
// Committed register plus its inverted shadow copy. A commit strobe loads
// both copies; mismatch_o flags any disagreement between them.
module shadow_store
    import ctrl_shadow_pkg::*;
#(
    parameter int unsigned DW     = CTRL_DW,
    parameter ctrl_mode_e  RESVAL = CTRL_MODE_DEFAULT
) (
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic          commit_i,
    input  logic [DW-1:0] wd_i,
    output logic [DW-1:0] q_o,
    output logic          mismatch_o
);

    logic [DW-1:0] main_d;
    logic [DW-1:0] main_q;
    logic [DW-1:0] shadow_d;
    logic [DW-1:0] shadow_q;

    // Next value of both copies: load on commit, otherwise hold.
    always_comb begin
        main_d   = main_q;
        shadow_d = shadow_q;
        if (commit_i) begin
            main_d   = wd_i;
            shadow_d = ~wd_i;
        end
    end

    // Storage flops; reset loads RESVAL and its complement.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            main_q   <= DW'(RESVAL);
            shadow_q <= ~DW'(RESVAL);
        end else begin
            main_q   <= main_d;
            shadow_q <= shadow_d;
        end
    end

    // Integrity check between the two copies.
    always_comb begin
        mismatch_o = (main_q != ~shadow_q);
    end

    assign q_o = main_q;

endmodule

// File: rtl/ctrl_shadow_reg.sv
// Shadowed control register with two-phase write commit and a registered
// read response. Optional macro CTRL_SHADOW_WRITE_ONCE_EN: after the first
// commit following reset, further commits are discarded until reset.
module ctrl_shadow_reg
    import ctrl_shadow_pkg::*;
#(
    parameter int unsigned DW     = CTRL_DW,
    parameter ctrl_mode_e  RESVAL = CTRL_MODE_DEFAULT
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    ctrl_shadow_reg_if.slave         bus,
    output logic [DW-1:0]            q_o,
    output logic                     phase_o,
    output logic                     update_err_o,
    output logic                     storage_err_o
);

    phase_e        phase_d;
    phase_e        phase_q;
    logic [DW-1:0] staged_d;
    logic [DW-1:0] staged_q;
    logic          update_err_d;
    logic          update_err_q;
    logic          storage_err_d;
    logic          storage_err_q;
    logic          rd_valid_d;
    logic          rd_valid_q;
    logic [DW-1:0] rd_data_d;
    logic [DW-1:0] rd_data_q;
    logic          match;
    logic          commit;
    logic          mismatch;
    logic [DW-1:0] q;

    // Staging FSM: first write stages, second write commits or flags error;
    // a lone read while staged abandons the staged value.
    always_comb begin
        phase_d      = phase_q;
        staged_d     = staged_q;
        update_err_d = 1'b0;
        match        = 1'b0;
        unique case (phase_q)
            PH_IDLE: begin
                if (bus.we_i) begin
                    staged_d = bus.wd_i;
                    phase_d  = PH_STAGED;
                end
            end
            PH_STAGED: begin
                if (bus.we_i) begin
                    phase_d = PH_IDLE;
                    if (bus.wd_i == staged_q) begin
                        match = 1'b1;
                    end else begin
                        update_err_d = 1'b1;
                    end
                end else if (bus.re_i) begin
                    phase_d = PH_IDLE;
                end
            end
            default: phase_d = PH_IDLE;
        endcase
    end

`ifdef CTRL_SHADOW_WRITE_ONCE_EN
    logic lock_d;
    logic lock_q;

    // Lock engages on the first commit and stays until reset.
    always_comb begin
        commit = match & ~lock_q;
        lock_d = lock_q | commit;
    end

    // Lock flop.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            lock_q <= 1'b0;
        end else begin
            lock_q <= lock_d;
        end
    end
`else
    // Every matching pair commits.
    always_comb begin
        commit = match;
    end
`endif

    shadow_store #(
        .DW     (DW),
        .RESVAL (RESVAL)
    ) u_store (
        .clk_i      (clk_i),
        .rst_i      (rst_i),
        .commit_i   (commit),
        .wd_i       (bus.wd_i),
        .q_o        (q),
        .mismatch_o (mismatch)
    );

    // Read response captures the pre-write value; sticky storage error.
    always_comb begin
        rd_valid_d    = bus.re_i;
        rd_data_d     = bus.re_i ? q : rd_data_q;
        storage_err_d = storage_err_q | mismatch;
    end

    // Control and response flops.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            phase_q       <= PH_IDLE;
            staged_q      <= '0;
            update_err_q  <= 1'b0;
            storage_err_q <= 1'b0;
            rd_valid_q    <= 1'b0;
            rd_data_q     <= '0;
        end else begin
            phase_q       <= phase_d;
            staged_q      <= staged_d;
            update_err_q  <= update_err_d;
            storage_err_q <= storage_err_d;
            rd_valid_q    <= rd_valid_d;
            rd_data_q     <= rd_data_d;
        end
    end

    assign q_o            = q;
    assign phase_o        = phase_q;
    assign update_err_o   = update_err_q;
    assign storage_err_o  = storage_err_q;
    assign bus.rd_valid_o = rd_valid_q;
    assign bus.rd_data_o  = rd_data_q;

endmodule

// File: tb/tb_ctrl_shadow_reg.sv
// Self-checking bench for ctrl_shadow_reg: directed scenarios plus random
// traffic against a behavioural model of the write/read protocol.
module tb_ctrl_shadow_reg;

`ifdef CTRL_SHADOW_WRITE_ONCE_EN
    localparam bit WO = 1'b1;
`else
    localparam bit WO = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [4:0] q_o;
    logic       phase_o;
    logic       update_err_o;
    logic       storage_err_o;

    int total = 0;
    int bad   = 0;

    // Behavioural model state
    logic [4:0] m_q;
    logic [4:0] m_staged;
    bit         m_have_stage;
    bit         m_locked;
    bit         m_serr;
    bit         m_fault;
    bit         m_rdv;
    logic [4:0] m_rdd;
    bit         m_uerr;
    logic [4:0] fault_val;

    ctrl_shadow_reg_if #(.DW(5)) bus ();

    ctrl_shadow_reg #(
        .DW     (5),
        .RESVAL (ctrl_shadow_pkg::CTRL_MODE_DEFAULT)
    ) dut (
        .clk_i         (clk),
        .rst_i         (rst),
        .bus           (bus),
        .q_o           (q_o),
        .phase_o       (phase_o),
        .update_err_o  (update_err_o),
        .storage_err_o (storage_err_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clock cycle: drive inputs, advance model on the edge, check all outputs.
    task automatic step(input bit r, input bit we, input logic [4:0] wd, input bit re);
        rst       = r;
        bus.we_i  = we;
        bus.wd_i  = wd;
        bus.re_i  = re;
        @(posedge clk);
        if (r) begin
            m_q = 5'h1F; m_staged = 5'h00; m_have_stage = 0; m_locked = 0;
            m_serr = 0; m_rdv = 0; m_rdd = 5'h00; m_uerr = 0;
        end else begin
            m_rdv  = re;
            if (re) m_rdd = m_q;
            m_uerr = 0;
            if (m_fault) m_serr = 1;
            if (we) begin
                if (!m_have_stage) begin
                    m_staged = wd;
                    m_have_stage = 1;
                end else begin
                    if (wd == m_staged) begin
                        if (!m_locked) begin
                            m_q = wd;
                            m_locked = WO;
                        end
                    end else begin
                        m_uerr = 1;
                    end
                    m_have_stage = 0;
                end
            end else if (re) begin
                m_have_stage = 0;
            end
        end
        #1;
        chk("q_o", 32'(q_o), 32'(m_q));
        chk("phase_o", 32'(phase_o), 32'(m_have_stage));
        chk("rd_valid_o", 32'(bus.rd_valid_o), 32'(m_rdv));
        chk("rd_data_o", 32'(bus.rd_data_o), 32'(m_rdd));
        chk("update_err_o", 32'(update_err_o), 32'(m_uerr));
        chk("storage_err_o", 32'(storage_err_o), 32'(m_serr));
    endtask

    task automatic do_reset();
        step(1, 0, 5'h00, 0);
        step(1, 1, 5'h0A, 1);
        chk("rst_q", 32'(q_o), 32'h1F);
        chk("rst_phase", 32'(phase_o), 32'h0);
    endtask

    initial begin
        logic [4:0] wd;
        bit         we;
        bit         re;
        m_fault  = 0;
        bus.we_i = 0;
        bus.wd_i = '0;
        bus.re_i = 0;

        // Reset, then read
        do_reset();
        chk("rst_rdv", 32'(bus.rd_valid_o), 32'h0);
        chk("rst_rdd", 32'(bus.rd_data_o), 32'h0);
        step(0, 0, 5'h00, 1);
        chk("read_rdv", 32'(bus.rd_valid_o), 32'h1);
        chk("read_rdd", 32'(bus.rd_data_o), 32'h1F);
        step(0, 0, 5'h00, 0);
        chk("read_rdv_drop", 32'(bus.rd_valid_o), 32'h0);
        chk("read_rdd_hold", 32'(bus.rd_data_o), 32'h1F);

        // Matching pair
        step(0, 1, 5'h15, 0);
        chk("pair_phase1", 32'(phase_o), 32'h1);
        chk("pair_q_hold", 32'(q_o), 32'h1F);
        step(0, 1, 5'h15, 0);
        chk("pair_phase0", 32'(phase_o), 32'h0);
        chk("pair_q", 32'(q_o), 32'h15);
        chk("pair_uerr", 32'(update_err_o), 32'h0);

        // Mismatched pair
        do_reset();
        step(0, 1, 5'h15, 0);
        step(0, 1, 5'h0A, 0);
        chk("mis_uerr", 32'(update_err_o), 32'h1);
        chk("mis_q", 32'(q_o), 32'h1F);
        chk("mis_phase", 32'(phase_o), 32'h0);
        step(0, 0, 5'h00, 0);
        chk("mis_uerr_pulse", 32'(update_err_o), 32'h0);

        // Read aborts staging; next write re-stages
        step(0, 1, 5'h15, 0);
        step(0, 0, 5'h00, 1);
        chk("abort_rdd", 32'(bus.rd_data_o), 32'h1F);
        chk("abort_phase", 32'(phase_o), 32'h0);
        step(0, 1, 5'h15, 0);
        chk("restage_phase", 32'(phase_o), 32'h1);
        chk("restage_q", 32'(q_o), 32'h1F);
        chk("restage_uerr", 32'(update_err_o), 32'h0);

        // Simultaneous write and read in PH_STAGED
        do_reset();
        step(0, 1, 5'h0A, 0);
        step(0, 1, 5'h0A, 1);
        chk("simul_rdd", 32'(bus.rd_data_o), 32'h1F);
        chk("simul_q", 32'(q_o), 32'h0A);
        chk("simul_phase", 32'(phase_o), 32'h0);

        // Storage fault: corrupt shadow bit 0
        do_reset();
        step(0, 0, 5'h00, 0);
        fault_val = ~m_q ^ 5'h01;
        force dut.u_store.shadow_q = fault_val;
        m_fault = 1;
        step(0, 0, 5'h00, 0);
        chk("serr_set", 32'(storage_err_o), 32'h1);
        release dut.u_store.shadow_q;
        m_fault = 0;
        step(0, 1, 5'h15, 0);
        step(0, 1, 5'h15, 0);
        step(0, 0, 5'h00, 0);
        chk("serr_sticky", 32'(storage_err_o), 32'h1);
        do_reset();
        chk("serr_clear", 32'(storage_err_o), 32'h0);

`ifdef CTRL_SHADOW_WRITE_ONCE_EN
        // Write-once lock
        do_reset();
        step(0, 1, 5'h15, 0);
        step(0, 1, 5'h15, 0);
        step(0, 1, 5'h00, 0);
        step(0, 1, 5'h00, 0);
        chk("wo_q_locked", 32'(q_o), 32'h15);
        step(0, 1, 5'h03, 0);
        step(0, 1, 5'h04, 0);
        chk("wo_uerr", 32'(update_err_o), 32'h1);
        do_reset();
        step(0, 1, 5'h00, 0);
        step(0, 1, 5'h00, 0);
        chk("wo_after_rst", 32'(q_o), 32'h00);
`endif

        // Random traffic, including occasional resets
        for (int i = 0; i < 600; i++) begin
            we = ($urandom_range(0, 1) == 1);
            re = ($urandom_range(0, 3) == 0);
            if (m_have_stage && $urandom_range(0, 2) != 0)
                wd = m_staged;
            else
                wd = 5'($urandom);
            step(($urandom_range(0, 63) == 0), we, wd, re);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
